// File: rtl/sqrt_seq.sv
// Sequencer in front of the iterative sqrt core: takes one operand, runs the core, returns {operand, root}.
// Define SQRT_SEQ_TIMEOUT_EN to add start/done watchdogs that force an error result when the core stalls.
module sqrt_seq #(
    parameter int DW       = 8,
    parameter int START_TO = 4,
    parameter int DONE_TO  = 64
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          core_enb_o,
    output logic [DW-1:0] core_dt_o,
    input  logic          core_busy_i,
    input  logic [DW-1:0] core_dt_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_op_o,
    output logic [DW-1:0] out_root_o,
    output logic          out_err_o,
    output logic [2:0]    dbg_state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;

    // Streams: a transfer happens on a rising edge where valid and ready are both high;
    // a producer keeps valid and data stable until that edge.

    logic [2:0]    state;
    logic [DW-1:0] op;

`ifdef SQRT_SEQ_TIMEOUT_EN
    localparam int MAX_TO = (START_TO > DONE_TO) ? START_TO : DONE_TO;
    localparam int CW     = $clog2(MAX_TO + 2);
    logic [CW-1:0] cnt;
    logic          err;
    assign out_err_o = err;
`else
    assign out_err_o = 1'b0;
`endif

    assign in_ready_o = (state == IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            op          <= '0;
            core_dt_o   <= '0;
            core_enb_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_op_o    <= '0;
            out_root_o  <= '0;
`ifdef SQRT_SEQ_TIMEOUT_EN
            cnt         <= '0;
            err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        op         <= in_data_i;
                        core_dt_o  <= in_data_i;
                        core_enb_o <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
`ifdef SQRT_SEQ_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (core_busy_i) begin
                        state <= WAIT_DONE;
`ifdef SQRT_SEQ_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (cnt == CW'(START_TO)) begin
                        // Core never started: report an all-ones root flagged as an error.
                        out_root_o  <= '1;
                        out_op_o    <= op;
                        err         <= 1'b1;
                        core_enb_o  <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!core_busy_i) begin
                        out_root_o  <= core_dt_i;
                        out_op_o    <= op;
                        core_enb_o  <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
`ifdef SQRT_SEQ_TIMEOUT_EN
                    end else if (cnt == CW'(DONE_TO)) begin
                        out_root_o  <= '1;
                        out_op_o    <= op;
                        err         <= 1'b1;
                        core_enb_o  <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
`ifdef SQRT_SEQ_TIMEOUT_EN
                        err         <= 1'b0;
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
